// File: rtl/dma_axi_pkg.sv
// Shared AXI read-side constants for the DMA channel blocks.
package dma_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] DEF_C_ID = 4'd1;
  localparam logic [3:0] DEF_D_ID = 4'd2;

  localparam logic [2:0] AR_SIZE_RST = 3'd2;

  typedef enum logic {
    GNT_C = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/dma_rr_arb2.sv
// Two-way round-robin arbiter with one-hot grant; bit 0 = C, bit 1 = D.
module dma_rr_arb2
  import dma_axi_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  gnt_e last_grant;

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == GNT_C) ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  // Starts at D so that C wins the first tie after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= GNT_D;
    end else if (|gnt) begin
      last_grant <= gnt[0] ? GNT_C : GNT_D;
    end
  end

endmodule

// File: rtl/dma_axi_rd_arbiter.sv
// Shares one AXI read master between the command fetch (C) and data read (D) engines.
module dma_axi_rd_arbiter
  import dma_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128,
  parameter logic [3:0]  C_ID   = DEF_C_ID,
  parameter logic [3:0]  D_ID   = DEF_D_ID
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c_arvalid,
  output logic              c_arready,
  input  logic [ADDR_W-1:0] c_araddr,
  input  logic [3:0]        c_arlen,
  input  logic [2:0]        c_arsize,
  input  logic [1:0]        c_arburst,
  input  logic              d_arvalid,
  output logic              d_arready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [3:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic [1:0]        d_arburst,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARID,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              c_rvalid,
  output logic              d_rvalid,
  input  logic              c_rready,
  input  logic              d_rready,
  output logic              unk_id_err,
  output logic              busy
);

  logic       c_out, d_out;
  logic       ar_free;
  logic [1:0] req, gnt;
  logic       rid_c, rid_d;
  logic       c_clr, d_clr;

  assign ar_free = ~ARVALID | ARREADY;
  assign req     = {d_arvalid & ~d_out, c_arvalid & ~c_out};

  dma_rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .en     (ar_free),
    .req    (req),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      ARID      <= '0;
      ARLEN     <= '0;
      ARSIZE    <= AR_SIZE_RST;
      ARBURST   <= '0;
      c_arready <= 1'b0;
      d_arready <= 1'b0;
    end else begin
      c_arready <= gnt[0];
      d_arready <= gnt[1];
      if (ar_free) begin
        ARVALID <= |gnt;
        if (gnt[0]) begin
          ARADDR  <= c_araddr;
          ARID    <= C_ID;
          ARLEN   <= c_arlen;
          ARSIZE  <= c_arsize;
          ARBURST <= c_arburst;
        end else if (gnt[1]) begin
          ARADDR  <= d_araddr;
          ARID    <= D_ID;
          ARLEN   <= d_arlen;
          ARSIZE  <= d_arsize;
          ARBURST <= d_arburst;
        end
      end
    end
  end

  assign rid_c    = (RID == C_ID);
  assign rid_d    = (RID == D_ID);
  assign c_rvalid = RVALID & rid_c;
  assign d_rvalid = RVALID & rid_d;
  assign RREADY   = rid_c ? c_rready : (rid_d ? d_rready : 1'b1);
  assign rdata    = RDATA;
  assign rresp    = RRESP;
  assign rlast    = RLAST;

  assign c_clr = RVALID & RREADY & RLAST & rid_c;
  assign d_clr = RVALID & RREADY & RLAST & rid_d;

  // A load in the same cycle as the burst's final beat leaves the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_out      <= 1'b0;
      d_out      <= 1'b0;
      unk_id_err <= 1'b0;
    end else begin
      c_out      <= gnt[0] | (c_out & ~c_clr);
      d_out      <= gnt[1] | (d_out & ~d_clr);
      unk_id_err <= RVALID & ~rid_c & ~rid_d;
    end
  end

  assign busy = ARVALID | c_out | d_out;

endmodule

// File: tb/tb_dma_axi_rd_arbiter.sv
// Scoreboard bench for dma_axi_rd_arbiter: AR and R expectations queued by stimulus, popped by a monitor.
module tb_dma_axi_rd_arbiter;
  import dma_axi_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         c_arvalid, c_arready, d_arvalid, d_arready;
  logic [31:0]  c_araddr, d_araddr;
  logic [3:0]   c_arlen, d_arlen;
  logic [2:0]   c_arsize, d_arsize;
  logic [1:0]   c_arburst, d_arburst;
  logic         ARVALID, ARREADY;
  logic [31:0]  ARADDR;
  logic [3:0]   ARID, ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic [3:0]   RID;
  logic [127:0] RDATA, rdata;
  logic [1:0]   RRESP, rresp;
  logic         RLAST, RVALID, RREADY, rlast;
  logic         c_rvalid, d_rvalid, c_rready, d_rready, unk_id_err, busy;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_t;

  ar_t ar_q[$];
  r_t  c_q[$];
  r_t  d_q[$];

  int tests = 0;
  int fails = 0;
  int c_ack_cnt = 0;
  int d_ack_cnt = 0;

  dma_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(128), .C_ID(4'd1), .D_ID(4'd2)) dut (
    .clk(clk), .resetn(resetn),
    .c_arvalid(c_arvalid), .c_arready(c_arready), .c_araddr(c_araddr),
    .c_arlen(c_arlen), .c_arsize(c_arsize), .c_arburst(c_arburst),
    .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr),
    .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arburst(d_arburst),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .c_rvalid(c_rvalid), .d_rvalid(d_rvalid), .c_rready(c_rready), .d_rready(d_rready),
    .unk_id_err(unk_id_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=time limit reached req=$finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=%0h req=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle, i.e. the values seen by the next rising edge.
  always @(negedge clk) begin
    ar_t ea;
    r_t  er;
    if (c_arready) c_ack_cnt++;
    if (d_arready) d_ack_cnt++;
    if (ARVALID && ARREADY) begin
      if (ar_q.size() == 0) check("ar_unexpected", 160'(ARADDR), 160'hDEAD);
      else begin
        ea = ar_q.pop_front();
        check("ar_hs", 160'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST}), 160'(ea));
      end
    end
    if (c_rvalid && c_rready) begin
      if (c_q.size() == 0) check("c_r_unexpected", 160'(rdata), 160'hDEAD);
      else begin
        er = c_q.pop_front();
        check("c_r_beat", 160'({rdata, rresp, rlast}), 160'(er));
      end
    end
    if (d_rvalid && d_rready) begin
      if (d_q.size() == 0) check("d_r_unexpected", 160'(rdata), 160'hDEAD);
      else begin
        er = d_q.pop_front();
        check("d_r_beat", 160'({rdata, rresp, rlast}), 160'(er));
      end
    end
  end

  task automatic idle_inputs();
    c_arvalid = 0; c_araddr = '0; c_arlen = '0; c_arsize = 3'd4; c_arburst = AXI_BURST_INCR;
    d_arvalid = 0; d_araddr = '0; d_arlen = '0; d_arsize = 3'd4; d_arburst = AXI_BURST_INCR;
    ARREADY = 1; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
    c_rready = 1; d_rready = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_arvalid"}, 160'(ARVALID), 160'(0));
    check({tag, "_araddr"},  160'(ARADDR),  160'(0));
    check({tag, "_arid"},    160'(ARID),    160'(0));
    check({tag, "_arlen"},   160'(ARLEN),   160'(0));
    check({tag, "_arsize"},  160'(ARSIZE),  160'(2));
    check({tag, "_arburst"}, 160'(ARBURST), 160'(0));
    check({tag, "_arready"}, 160'({c_arready, d_arready}), 160'(0));
    check({tag, "_unk"},     160'(unk_id_err), 160'(0));
    check({tag, "_busy"},    160'(busy), 160'(0));
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    tick();
  endtask

  task automatic wait_ack(input bit is_d, output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (is_d ? d_arready : c_arready) break;
    end
    if (!(is_d ? d_arready : c_arready)) check(is_d ? "d_ack_timeout" : "c_ack_timeout", 160'(0), 160'(1));
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [127:0] data,
                        input logic [1:0] resp, input logic last);
    r_t e;
    e = '{data: data, resp: resp, last: last};
    if (id == 4'd1) c_q.push_back(e);
    else if (id == 4'd2) d_q.push_back(e);
    RVALID = 1; RID = id; RDATA = data; RRESP = resp; RLAST = last;
    tick();
    RVALID = 0; RLAST = 0;
  endtask

  initial begin
    int n;
    int cb, db;
    logic [6:0] pat;
    int beat;

    idle_inputs();
    resetn = 0;
    tick(); tick();
    check_reset_vals("rst");
    resetn = 1;
    tick();

    // C alone: one-cycle request-to-ARVALID latency.
    c_arvalid = 1; c_araddr = 32'h1000; c_arlen = 4'd0;
    ar_q.push_back('{id: 4'd1, addr: 32'h1000, len: 4'd0, size: 3'd4, burst: AXI_BURST_INCR});
    wait_ack(0, n);
    check("c_latency", 160'(n), 160'(1));
    check("c_arvalid_up", 160'(ARVALID), 160'(1));
    c_arvalid = 0;
    tick();

    // C re-request must wait for its RLAST.
    c_arvalid = 1; c_araddr = 32'h2000;
    ar_q.push_back('{id: 4'd1, addr: 32'h2000, len: 4'd0, size: 3'd4, burst: AXI_BURST_INCR});
    cb = c_ack_cnt;
    tick(); tick(); tick(); tick();
    check("c_blocked_ack", 160'(c_ack_cnt - cb), 160'(0));
    check("c_blocked_arvalid", 160'(ARVALID), 160'(0));
    check("c_blocked_busy", 160'(busy), 160'(1));
    r_beat(4'd1, 128'hC0C0_0001, RESP_OKAY, 1'b1);
    wait_ack(0, n);
    check("c_rereq_latency", 160'(n), 160'(1));
    c_arvalid = 0;
    tick();

    // Tie after reset: C then D with no idle cycle.
    apply_reset();
    c_arvalid = 1; c_araddr = 32'hA000; c_arlen = 4'd0;
    d_arvalid = 1; d_araddr = 32'hB000; d_arlen = 4'd3;
    ar_q.push_back('{id: 4'd1, addr: 32'hA000, len: 4'd0, size: 3'd4, burst: AXI_BURST_INCR});
    ar_q.push_back('{id: 4'd2, addr: 32'hB000, len: 4'd3, size: 3'd4, burst: AXI_BURST_INCR});
    tick();
    check("tie_first_ack", 160'({d_arready, c_arready}), 160'(2'b01));
    check("tie_first_id", 160'(ARID), 160'(1));
    c_arvalid = 0;
    tick();
    check("tie_second_ack", 160'({d_arready, c_arready}), 160'(2'b10));
    check("tie_second_id", 160'({ARVALID, ARID}), 160'({1'b1, 4'd2}));
    d_arvalid = 0;
    tick();
    r_beat(4'd1, 128'hC0C0_00A0, RESP_OKAY, 1'b1);

    // Backpressure: fields frozen, no extra arready pulse.
    ARREADY = 0;
    cb = c_ack_cnt; db = d_ack_cnt;
    c_arvalid = 1; c_araddr = 32'h3000; c_arlen = 4'd1;
    ar_q.push_back('{id: 4'd1, addr: 32'h3000, len: 4'd1, size: 3'd4, burst: AXI_BURST_INCR});
    wait_ack(0, n);
    c_arvalid = 0; c_araddr = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", 160'({ARVALID, ARID, ARADDR, ARLEN}), 160'({1'b1, 4'd1, 32'h3000, 4'd1}));
    end
    check("bp_c_pulses", 160'(c_ack_cnt - cb), 160'(1));
    check("bp_d_pulses", 160'(d_ack_cnt - db), 160'(0));
    ARREADY = 1;
    tick();
    check("bp_release", 160'(ARVALID), 160'(0));

    // D burst of 4 beats with d_rready toggling; D re-request waits for the last beat.
    d_arvalid = 1; d_araddr = 32'h5000; d_arlen = 4'd0;
    ar_q.push_back('{id: 4'd2, addr: 32'h5000, len: 4'd0, size: 3'd4, burst: AXI_BURST_INCR});
    pat = 7'b1010110;
    beat = 0;
    for (int i = 0; i < 7; i++) begin
      d_rready = pat[i];
      RVALID = 1; RID = 4'd2; RDATA = 128'hD000 + 128'(beat);
      RRESP = (beat == 2) ? RESP_SLVERR : RESP_OKAY;
      RLAST = (beat == 3);
      if (pat[i]) d_q.push_back('{data: 128'hD000 + 128'(beat), resp: RRESP, last: RLAST});
      #1;
      check("d_rready_route", 160'({RREADY, c_rvalid, d_rvalid}), 160'({pat[i], 1'b0, 1'b1}));
      tick();
      check("d_blocked_ack", 160'(d_arready), 160'(0));
      if (pat[i]) beat++;
    end
    RVALID = 0; RLAST = 0; d_rready = 1;
    wait_ack(1, n);
    check("d_rereq_latency", 160'(n), 160'(1));
    d_arvalid = 0;
    tick();

    r_beat(4'd1, 128'hC0C0_3000, RESP_OKAY, 1'b0);
    r_beat(4'd1, 128'hC0C0_3001, RESP_DECERR, 1'b1);

    // Unknown RID drains and pulses the error for one cycle.
    c_rready = 0; d_rready = 0;
    RVALID = 1; RID = 4'd7; RDATA = 128'h7777;
    #1;
    check("unk_route", 160'({RREADY, c_rvalid, d_rvalid, unk_id_err}), 160'(4'b1000));
    tick();
    check("unk_pulse", 160'(unk_id_err), 160'(1));
    RVALID = 0; RID = '0;
    tick();
    check("unk_clear", 160'(unk_id_err), 160'(0));
    c_rready = 1; d_rready = 1;

    // Async reset with D outstanding and a C request held by ARREADY=0.
    ARREADY = 0;
    c_arvalid = 1; c_araddr = 32'h6000;
    tick();
    check("pre_rst_state", 160'({ARVALID, busy, ARID}), 160'({1'b1, 1'b1, 4'd1}));
    c_arvalid = 0;
    resetn = 0;
    #2;
    check_reset_vals("async_rst");
    tick();
    check_reset_vals("held_rst");
    resetn = 1;
    ARREADY = 1;
    tick();
    d_arvalid = 1; d_araddr = 32'h7000; d_arlen = 4'd0;
    ar_q.push_back('{id: 4'd2, addr: 32'h7000, len: 4'd0, size: 3'd4, burst: AXI_BURST_INCR});
    wait_ack(1, n);
    check("post_rst_d_latency", 160'(n), 160'(1));
    d_arvalid = 0;
    tick(); tick();

    check("ar_q_empty", 160'(ar_q.size()), 160'(0));
    check("rq_empty", 160'(c_q.size() + d_q.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
